// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : router_ctrl
// Brief    : Packet FSM and per-port read-timeout controller for a 1x3 router.
// Revision : 1.0 - initial release
// ============================================================================
module router_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full_0,
    input  logic       fifo_full_1,
    input  logic       fifo_full_2,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int         C_CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_FIRE_AT = C_CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;
    logic [1:0] w_addr;
    logic       w_sel_empty;
    logic       w_soft_hit;
    logic [2:0] w_empty_vec;
    logic [2:0] w_read_vec;
    logic [2:0] r_soft_reset;

    assign w_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_read_vec  = {read_enb_2, read_enb_1, read_enb_0};

    // The header is on data_in only while decoding; afterwards the latched copy rules.
    assign w_addr = (r_state == DECODE_ADDRESS) ? data_in : r_addr;

    always_comb begin
        fifo_full   = 1'b0;
        w_sel_empty = 1'b0;
        case (w_addr)
            2'd0: begin fifo_full = fifo_full_0; w_sel_empty = fifo_empty_0; end
            2'd1: begin fifo_full = fifo_full_1; w_sel_empty = fifo_empty_1; end
            2'd2: begin fifo_full = fifo_full_2; w_sel_empty = fifo_empty_2; end
            default: begin fifo_full = 1'b0; w_sel_empty = 1'b0; end
        endcase
    end

    always_comb begin
        w_soft_hit = 1'b0;
        case (r_addr)
            2'd0:    w_soft_hit = r_soft_reset[0];
            2'd1:    w_soft_hit = r_soft_reset[1];
            2'd2:    w_soft_hit = r_soft_reset[2];
            default: w_soft_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE_ADDRESS && w_next_state != DECODE_ADDRESS)
                r_addr <= data_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state != DECODE_ADDRESS && w_soft_hit) begin
            w_next_state = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && w_addr != 2'd3)
                        w_next_state = w_sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_sel_empty)
                        w_next_state = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        w_next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        w_next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        w_next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        w_next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        w_next_state = LOAD_PARITY;
                    else
                        w_next_state = LOAD_DATA;
                end
                LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: w_next_state = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add  = (r_state == DECODE_ADDRESS);
        lfd_state   = (r_state == LOAD_FIRST_DATA);
        ld_state    = (r_state == LOAD_DATA);
        full_state  = (r_state == FIFO_FULL_STATE);
        laf_state   = (r_state == LOAD_AFTER_FULL);
        rst_int_reg = (r_state == CHECK_PARITY_ERROR);
        busy        = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
        write_enb   = 3'b000;
        if (r_state == LOAD_FIRST_DATA || r_state == LOAD_DATA ||
            r_state == LOAD_AFTER_FULL || r_state == LOAD_PARITY) begin
            case (r_addr)
                2'd0:    write_enb = 3'b001;
                2'd1:    write_enb = 3'b010;
                2'd2:    write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

    assign vld_out_0 = !fifo_empty_0;
    assign vld_out_1 = !fifo_empty_1;
    assign vld_out_2 = !fifo_empty_2;

    // Pulse is registered one cycle early so it lands on the TIMEOUT-th unread cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_timeout
            logic [C_CNT_W-1:0] r_cnt;
            logic               w_idle;

            assign w_idle = !w_empty_vec[gi] && !w_read_vec[gi];

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_cnt            <= '0;
                    r_soft_reset[gi] <= 1'b0;
                end else if (!w_idle) begin
                    r_cnt            <= '0;
                    r_soft_reset[gi] <= 1'b0;
                end else if (r_cnt == C_FIRE_AT) begin
                    r_cnt            <= '0;
                    r_soft_reset[gi] <= 1'b1;
                end else begin
                    r_cnt            <= r_cnt + C_CNT_W'(1);
                    r_soft_reset[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign soft_reset_0 = r_soft_reset[0];
    assign soft_reset_1 = r_soft_reset[1];
    assign soft_reset_2 = r_soft_reset[2];

endmodule
`default_nettype wire
